chop_seq_ctrl: RTL

//  Sequencer for the chopper generator (chop_gen): holds host-written chop timing in a pending

---
 rtl/chop_seq_ctrl_pkg.sv | 11 +
 rtl/chop_seq_ctrl_if.sv | 33 +++
 rtl/chop_seq_ctrl_cfg_check.sv | 17 +
 rtl/chop_seq_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/chop_seq_ctrl_pkg.sv
// Shared constants for the chopper sequencer: state encoding and timing defaults.
package chop_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned MIN_HOLD   = 3;
  localparam int unsigned DEF_CHANGE = 500;
  localparam int unsigned DEF_MAX    = 1000;
endpackage

// File: rtl/chop_seq_ctrl_if.sv
// Host-side command/config bus and chop_gen-side drive bus of the chopper sequencer.
interface chop_seq_ctrl_if;
  logic [31:0] cfg_change_count;
  logic [31:0] cfg_max_count;
  logic [31:0] cfg_num_periods;
  logic        cfg_wr;
  logic        arm;
  logic        trigger;
  logic        soft_stop;
  logic        abort;
  logic        chop_en_o;
  logic [31:0] change_count_o;
  logic [31:0] max_count_o;
  logic        period_strobe_o;
  logic [31:0] run_count_o;
  logic [1:0]  state_o;
  logic        cfg_err_o;
  logic        done_o;

  modport master (
    output cfg_change_count, cfg_max_count, cfg_num_periods, cfg_wr,
           arm, trigger, soft_stop, abort,
    input  chop_en_o, change_count_o, max_count_o, period_strobe_o,
           run_count_o, state_o, cfg_err_o, done_o
  );

  modport slave (
    input  cfg_change_count, cfg_max_count, cfg_num_periods, cfg_wr,
           arm, trigger, soft_stop, abort,
    output chop_en_o, change_count_o, max_count_o, period_strobe_o,
           run_count_o, state_o, cfg_err_o, done_o
  );
endinterface

// File: rtl/chop_seq_ctrl_cfg_check.sv
// Combinational validity of a chop timing pair; also used by the host register file readback.
module chop_cfg_check #(
  parameter int unsigned MIN_HOLD = chop_pkg::MIN_HOLD
) (
  input  logic [31:0] change_count,
  input  logic [31:0] max_count,
  output logic        ok
);
  logic [31:0] high_len;

  // Subtract only when ordered so an inverted pair cannot wrap into a large "valid" length.
  always_comb begin
    high_len = '0;
    if (max_count > change_count) high_len = max_count - change_count;
    ok = (change_count >= MIN_HOLD) && (max_count > change_count) && (high_len >= MIN_HOLD);
  end
endmodule

// File: rtl/chop_seq_ctrl.sv
// Chopper sequencer: pending/active timing shadow regs, run FSM and period counter for chop_gen.
module chop_seq_ctrl #(
  parameter int unsigned MIN_HOLD   = chop_pkg::MIN_HOLD,
  parameter int unsigned DEF_CHANGE = chop_pkg::DEF_CHANGE,
  parameter int unsigned DEF_MAX    = chop_pkg::DEF_MAX
) (
  input  logic            clk,
  input  logic            reset_n,
  chop_seq_ctrl_if.slave  bus
);
  import chop_pkg::*;

  logic [1:0]  state_q, state_d;
  logic [31:0] pend_change_q, pend_change_d, pend_max_q, pend_max_d, pend_num_q, pend_num_d;
  logic [31:0] change_q, change_d, max_q, max_d, num_q, num_d;
  logic [31:0] phase_q, phase_d, run_q, run_d;
  logic        chop_en_q, chop_en_d, stop_pend_q, stop_pend_d;
  logic        cfg_err_q, cfg_err_d, done_q, done_d;
  logic        cfg_ok, wrap, last_period, stop_now;
  logic [31:0] run_inc;

  chop_cfg_check #(.MIN_HOLD(MIN_HOLD)) u_cfg_check (
    .change_count (bus.cfg_change_count),
    .max_count    (bus.cfg_max_count),
    .ok           (cfg_ok)
  );

  // Strobe is decoded from flops only, so it is high on the last sample of the period itself.
  assign wrap        = (state_q == ST_RUN) && (phase_q == max_q - 32'd1);
  assign last_period = (num_q != '0) && (({1'b0, run_q} + 33'd1) == {1'b0, num_q});
  assign stop_now    = stop_pend_q | bus.soft_stop;
  assign run_inc     = (run_q == '1) ? run_q : run_q + 32'd1;

  always_comb begin
    state_d       = state_q;
    pend_change_d = pend_change_q;
    pend_max_d    = pend_max_q;
    pend_num_d    = pend_num_q;
    change_d      = change_q;
    max_d         = max_q;
    num_d         = num_q;
    phase_d       = '0;
    run_d         = run_q;
    chop_en_d     = chop_en_q;
    stop_pend_d   = stop_pend_q;
    cfg_err_d     = cfg_err_q;
    done_d        = 1'b0;

    if (bus.cfg_wr) begin
      cfg_err_d = !cfg_ok;
      if (cfg_ok) begin
        pend_change_d = bus.cfg_change_count;
        pend_max_d    = bus.cfg_max_count;
        pend_num_d    = bus.cfg_num_periods;
      end
    end

    // Outside a run chop_gen is idle, so pending timing can follow freely.
    if (state_q != ST_RUN) begin
      change_d = pend_change_q;
      max_d    = pend_max_q;
      num_d    = pend_num_q;
    end

    if (bus.abort) begin
      state_d     = ST_IDLE;
      chop_en_d   = 1'b0;
      stop_pend_d = 1'b0;
      done_d      = (state_q == ST_RUN) || (state_q == ST_ARMED);
    end else begin
      case (state_q)
        ST_IDLE: if (bus.arm) begin
          state_d = ST_ARMED;
          run_d   = '0;
        end
        ST_ARMED: if (bus.trigger) begin
          state_d   = ST_RUN;
          chop_en_d = 1'b1;
        end
        ST_RUN: begin
          if (bus.soft_stop) stop_pend_d = 1'b1;
          if (wrap) begin
            change_d = pend_change_q;
            max_d    = pend_max_q;
            num_d    = pend_num_q;
            run_d    = run_inc;
            if (last_period || stop_now) begin
              state_d     = ST_DONE;
              chop_en_d   = 1'b0;
              stop_pend_d = 1'b0;
              done_d      = 1'b1;
            end
          end else begin
            phase_d = phase_q + 32'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pend_change_q <= DEF_CHANGE;
      pend_max_q    <= DEF_MAX;
      pend_num_q    <= '0;
      change_q      <= DEF_CHANGE;
      max_q         <= DEF_MAX;
      num_q         <= '0;
      phase_q       <= '0;
      run_q         <= '0;
      chop_en_q     <= 1'b0;
      stop_pend_q   <= 1'b0;
      cfg_err_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_change_q <= pend_change_d;
      pend_max_q    <= pend_max_d;
      pend_num_q    <= pend_num_d;
      change_q      <= change_d;
      max_q         <= max_d;
      num_q         <= num_d;
      phase_q       <= phase_d;
      run_q         <= run_d;
      chop_en_q     <= chop_en_d;
      stop_pend_q   <= stop_pend_d;
      cfg_err_q     <= cfg_err_d;
      done_q        <= done_d;
    end
  end

  assign bus.chop_en_o       = chop_en_q;
  assign bus.change_count_o  = change_q;
  assign bus.max_count_o     = max_q;
  assign bus.period_strobe_o = wrap;
  assign bus.run_count_o     = run_q;
  assign bus.state_o         = state_q;
  assign bus.cfg_err_o       = cfg_err_q;
  assign bus.done_o          = done_q;
endmodule
